// File: rtl/dram_page_controller.sv
// Page-granular DRAM model behind the cache: whole-page fills streamed one word per
// cycle and atomic whole-page write-backs, each with fixed cycle-exact latency.
module dram_page_controller #(
  parameter int unsigned WORD_SIZE     = 8,
  parameter int unsigned PAGE_SIZE     = 8,
  parameter int unsigned READ_LATENCY  = 8,
  parameter int unsigned WRITE_LATENCY = 9,
  parameter int unsigned ADDR_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [WORD_SIZE*PAGE_SIZE-1:0]  req_wdata,
  output logic                            rd_valid,
  output logic [$clog2(PAGE_SIZE)-1:0]    rd_idx,
  output logic [WORD_SIZE-1:0]            rd_data,
  output logic                            rd_last,
  output logic                            wr_done,
  output logic                            busy
);

  localparam int unsigned OFS     = $clog2(PAGE_SIZE);
  localparam int unsigned PW      = ADDR_WIDTH - OFS;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW      = $clog2(MAX_LAT);
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned DW      = WORD_SIZE * PAGE_SIZE;

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_BURST, WRITE_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          page_q, page_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic [OFS-1:0]         idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   wr_done_q, wr_done_d;
  logic                   ready_q, ready_d;
  logic                   busy_q;
  logic [WORD_SIZE-1:0]   rd_data_q;
  logic                   rd_load_c;
  logic [ADDR_WIDTH-1:0]  rd_addr_c;
  logic                   mem_we_c;
  logic                   unused_addr_lsb;

  logic [WORD_SIZE-1:0]   mem [DEPTH];

  // Offset bits are dropped: every access is page-aligned.
  assign unused_addr_lsb = ^req_addr[OFS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      page_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      wr_done_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      page_q    <= page_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      wr_done_q <= wr_done_d;
      ready_q   <= ready_d;
      busy_q    <= ~ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_load_c) begin
      rd_data_q <= mem[rd_addr_c];
    end
  end

  // Whole-page commit in a single cycle; a same-cycle reset suppresses it.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      for (int i = 0; i < PAGE_SIZE; i++) begin
        mem[{page_q, OFS'(i)}] <= wdata_q[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    wr_done_d = 1'b0;
    ready_d   = 1'b0;
    rd_load_c = 1'b0;
    rd_addr_c = {page_q, idx_q};
    mem_we_c  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          page_d  = req_addr[ADDR_WIDTH-1:OFS];
          wdata_d = req_wdata;
          ready_d = 1'b0;
          if (req_write) begin
            cnt_d   = CW'(WRITE_LATENCY - 2);
            state_d = WRITE_WAIT;
          end else begin
            cnt_d   = CW'(READ_LATENCY - 2);
            state_d = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = READ_BURST;
          valid_d   = 1'b1;
          idx_d     = '0;
          rd_load_c = 1'b1;
          rd_addr_c = {page_q, OFS'(0)};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      READ_BURST: begin
        if (last_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          idx_d     = idx_q + OFS'(1);
          valid_d   = 1'b1;
          last_d    = (idx_q == OFS'(PAGE_SIZE - 2));
          rd_load_c = 1'b1;
          rd_addr_c = {page_q, idx_q + OFS'(1)};
        end
      end
      WRITE_WAIT: begin
        // wr_done is visible for one cycle before the controller reopens.
        if (wr_done_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (cnt_q == '0) begin
          mem_we_c  = 1'b1;
          wr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rd_valid  = valid_q;
  assign rd_idx    = idx_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = last_q;
  assign wr_done   = wr_done_q;

endmodule
